// File: rtl/fm_writer.sv
// Full-match memory writer: buffers incoming full matches in a 2-entry skid FIFO
// and writes them into a BX-paged memory, tracking per-page count, overflow, order and flush.
module fm_writer #(
  parameter int RESDWIDTH  = 40,
  parameter int ACTIVE_MSB = RESDWIDTH - 5,
  parameter int ACTIVE_LSB = RESDWIDTH - 10,
  parameter int MEMSIZE    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_bx,
  input  logic [3:0]           BX_pipe,
  input  logic [RESDWIDTH-1:0] fullmatch_in,
  input  logic                 valid_in,
  output logic                 ready_o,
  output logic                 write_en,
  output logic [MEMSIZE+3:0]   write_addr,
  output logic [RESDWIDTH-1:0] write_data,
  output logic [5:0]           number_out,
  output logic                 done_o,
  output logic [5:0]           done_number,
  output logic [3:0]           done_bx,
  output logic                 overflow_o,
  output logic                 order_err_o,
  output logic                 flush_o
);

  localparam int KEYW = ACTIVE_MSB - ACTIVE_LSB + 1;

  logic [RESDWIDTH-1:0] fifo_mem [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           occ;

  logic [3:0]           page_bx;
  logic [MEMSIZE-1:0]   count;
  logic [KEYW-1:0]      last_key;
  logic                 have_last;

  logic                 accept;
  logic                 fifo_nonempty;
  logic                 fifo_pop;
  logic                 push;
  logic                 pop;
  logic [RESDWIDTH-1:0] pop_data;
  logic [KEYW-1:0]      pop_key;
  logic                 page_full;
  logic                 out_of_order;
  logic [1:0]           occ_next;

  always_comb begin
    accept        = valid_in && ready_o;
    fifo_nonempty = (occ != 2'd0);
    fifo_pop      = !new_bx && fifo_nonempty;
    // With an empty FIFO and no page change the accepted word bypasses storage.
    push          = accept && (new_bx || fifo_nonempty);
    pop           = !new_bx && (fifo_nonempty || accept);
    pop_data      = fifo_nonempty ? fifo_mem[rd_ptr] : fullmatch_in;
    pop_key       = pop_data[ACTIVE_MSB:ACTIVE_LSB];
    page_full     = &count;
    out_of_order  = have_last && (pop_key < last_key);
    if (new_bx) begin
      occ_next = {1'b0, accept};
    end else begin
      occ_next = occ + {1'b0, push} - {1'b0, fifo_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= fullmatch_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      occ         <= 2'd0;
      ready_o     <= 1'b1;
      page_bx     <= 4'd0;
      count       <= '0;
      last_key    <= '0;
      have_last   <= 1'b0;
      write_en    <= 1'b0;
      write_addr  <= '0;
      write_data  <= '0;
      done_o      <= 1'b0;
      done_number <= '0;
      done_bx     <= '0;
      overflow_o  <= 1'b0;
      order_err_o <= 1'b0;
      flush_o     <= 1'b0;
    end else begin
      occ     <= occ_next;
      ready_o <= (occ_next <= 2'd1);
      wr_ptr  <= wr_ptr ^ push;
      // A page change discards stored words by snapping the read pointer to the write pointer.
      rd_ptr  <= new_bx ? wr_ptr : (rd_ptr ^ fifo_pop);

      if (new_bx) begin
        write_en    <= 1'b0;
        done_o      <= 1'b1;
        done_number <= 6'(count);
        done_bx     <= page_bx;
        page_bx     <= BX_pipe;
        count       <= '0;
        last_key    <= '0;
        have_last   <= 1'b0;
        overflow_o  <= 1'b0;
        order_err_o <= 1'b0;
        flush_o     <= fifo_nonempty;
      end else begin
        done_o <= 1'b0;
        if (pop && !page_full) begin
          write_en   <= 1'b1;
          write_addr <= {page_bx, count};
          write_data <= pop_data;
          count      <= count + 1'b1;
          last_key   <= pop_key;
          have_last  <= 1'b1;
          if (out_of_order) begin
            order_err_o <= 1'b1;
          end
        end else begin
          write_en <= 1'b0;
          if (pop) begin
            overflow_o <= 1'b1;
          end
        end
      end
    end
  end

  assign number_out = 6'(count);

endmodule
